// File: rtl/switch_allocator.sv
// switch_allocator: per-cycle wormhole switch allocator for a router crossbar.
// One round-robin arbiter per output picks a head-flit winner; the output then
// stays locked to that input until the packet's tail flit is granted.
// Grants, crossbar selects and valids are combinational in the request cycle;
// round-robin pointers and lock state are registered.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   req_i        per input: a valid head-of-line flit is present
//   out_port_i   per input: requested output port index
//   head_i       per input: flit is a head flit
//   tail_i       per input: flit is a tail flit (head&tail = single-flit packet)
//   out_ready_i  per output: downstream can accept a flit this cycle
//   grant_o      per input: flit traverses the crossbar this cycle
//   sel_o        per output: crossbar select (winning input index)
//   valid_o      per output: output carries a flit this cycle
//   grant_cnt_o  per output: saturating count of valid cycles
//                (present only when SA_GRANT_COUNT_EN is defined)
module switch_allocator #(
    parameter int unsigned INPUT_NUM  = 5,
    parameter int unsigned OUTPUT_NUM = 5,
    localparam int unsigned SEL_SIZE  = (INPUT_NUM  > 1) ? $clog2(INPUT_NUM)  : 1,
    localparam int unsigned OUT_SIZE  = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [INPUT_NUM-1:0]                 req_i,
    input  logic [INPUT_NUM-1:0][OUT_SIZE-1:0]   out_port_i,
    input  logic [INPUT_NUM-1:0]                 head_i,
    input  logic [INPUT_NUM-1:0]                 tail_i,
    input  logic [OUTPUT_NUM-1:0]                out_ready_i,
    output logic [INPUT_NUM-1:0]                 grant_o,
    output logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  sel_o,
    output logic [OUTPUT_NUM-1:0]                valid_o
`ifdef SA_GRANT_COUNT_EN
    ,
    output logic [OUTPUT_NUM-1:0][15:0]          grant_cnt_o
`endif
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [SEL_SIZE-1:0] LAST_IDX = SEL_SIZE'(INPUT_NUM - 1);

    logic [OUTPUT_NUM-1:0]               state_q, state_d;
    logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0] owner_q, owner_d;
    logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0] ptr_q,   ptr_d;

    logic [INPUT_NUM-1:0]                grant_c;
    logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0] sel_c;
    logic [OUTPUT_NUM-1:0]               valid_c;

    logic [INPUT_NUM-1:0]                elig;
    logic                                found;
    logic [SEL_SIZE-1:0]                 win;
    logic [SEL_SIZE-1:0]                 idx;

    // Increment an input index modulo INPUT_NUM.
    function automatic logic [SEL_SIZE-1:0] inc_wrap(input logic [SEL_SIZE-1:0] x);
        return (x == LAST_IDX) ? '0 : x + SEL_SIZE'(1);
    endfunction

    // State registers: lock state, owner and round-robin pointer per output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Arbitration and next-state per output.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_c = '0;
        sel_c   = '0;
        valid_c = '0;
        elig    = '0;
        found   = 1'b0;
        win     = '0;
        idx     = '0;

        for (int unsigned o = 0; o < OUTPUT_NUM; o++) begin
            // Out-of-range port indices never match any o, so they are ignored.
            for (int unsigned i = 0; i < INPUT_NUM; i++) begin
                elig[i] = req_i[i] && (out_port_i[i] == OUT_SIZE'(o)) && out_ready_i[o]
                          && ((state_q[o] == IDLE) ? head_i[i]
                                                   : (owner_q[o] == SEL_SIZE'(i)));
            end

            found = 1'b0;
            win   = '0;
            if (state_q[o] == LOCKED) begin
                found = elig[owner_q[o]];
                win   = owner_q[o];
            end else begin
                // Round-robin scan starting at the pointer.
                idx = ptr_q[o];
                for (int unsigned k = 0; k < INPUT_NUM; k++) begin
                    if (!found && elig[idx]) begin
                        found = 1'b1;
                        win   = idx;
                    end
                    idx = inc_wrap(idx);
                end
            end

            if (found) begin
                valid_c[o] = 1'b1;
                sel_c[o]   = win;
                for (int unsigned i = 0; i < INPUT_NUM; i++) begin
                    if (win == SEL_SIZE'(i)) begin
                        grant_c[i] = 1'b1;
                    end
                end
                if (state_q[o] == IDLE) begin
                    if (tail_i[win]) begin
                        ptr_d[o] = inc_wrap(win);
                    end else begin
                        state_d[o] = LOCKED;
                        owner_d[o] = win;
                    end
                end else if (tail_i[win]) begin
                    state_d[o] = IDLE;
                    ptr_d[o]   = inc_wrap(owner_q[o]);
                end
            end
        end
    end

    // Outputs are forced low for as long as reset is held.
    assign grant_o = rst ? grant_c : '0;
    assign sel_o   = rst ? sel_c   : '0;
    assign valid_o = rst ? valid_c : '0;

`ifdef SA_GRANT_COUNT_EN
    logic [OUTPUT_NUM-1:0][15:0] cnt_q, cnt_d;

    // Saturating per-output traversal counters.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned o = 0; o < OUTPUT_NUM; o++) begin
            if (valid_o[o] && (cnt_q[o] != 16'hFFFF)) begin
                cnt_d[o] = cnt_q[o] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Testbench for switch_allocator: table-driven per-cycle vectors checked through
// an expectation queue, plus hand-written reset and counter sequences.
module tb_switch_allocator;

    logic             clk;
    logic             rst;
    logic [4:0]       req;
    logic [4:0][2:0]  out_port;
    logic [4:0]       head;
    logic [4:0]       tail;
    logic [4:0]       ready;
    logic [4:0]       grant;
    logic [4:0][2:0]  sel;
    logic [4:0]       valid;
`ifdef SA_GRANT_COUNT_EN
    logic [4:0][15:0] grant_cnt;
`endif

    int n_cmp;
    int n_bad;

    switch_allocator #(.INPUT_NUM(5), .OUTPUT_NUM(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .out_port_i  (out_port),
        .head_i      (head),
        .tail_i      (tail),
        .out_ready_i (ready),
        .grant_o     (grant),
        .sel_o       (sel),
        .valid_o     (valid)
`ifdef SA_GRANT_COUNT_EN
        ,
        .grant_cnt_o (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  req;
        logic [14:0] port;
        logic [4:0]  head;
        logic [4:0]  tail;
        logic [4:0]  ready;
        logic [4:0]  grant;
        logic [4:0]  valid;
        logic [14:0] sel;
    } vec_t;

    vec_t vecs[$];
    vec_t expq[$];

    function automatic vec_t mk(input string name, input logic [4:0] r, input logic [14:0] p,
                                input logic [4:0] h, input logic [4:0] t, input logic [4:0] rdy,
                                input logic [4:0] g, input logic [4:0] v, input logic [14:0] s);
        vec_t x;
        x.name = name; x.req = r; x.port = p; x.head = h; x.tail = t; x.ready = rdy;
        x.grant = g; x.valid = v; x.sel = s;
        return x;
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then compare combinational outputs.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        req = v.req; out_port = v.port; head = v.head; tail = v.tail; ready = v.ready;
        expq.push_back(v);
        #2;
        if (expq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got empty scoreboard expected one entry", v.name);
        end else begin
            e = expq.pop_front();
            check({e.name, ".grant"}, 15'(grant), 15'(e.grant));
            check({e.name, ".valid"}, 15'(valid), 15'(e.valid));
            check({e.name, ".sel"},   15'(sel),   e.sel);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        req = 5'b00001; out_port = '0; head = 5'b00001; tail = 5'b00001; ready = '1;

        // Reset held: a live request must still produce all-zero outputs.
        repeat (2) @(negedge clk);
        #1;
        check("rst.grant", 15'(grant), 15'd0);
        check("rst.valid", 15'(valid), 15'd0);
        check("rst.sel",   15'(sel),   15'd0);
`ifdef SA_GRANT_COUNT_EN
        check("rst.cnt0", 15'(grant_cnt[0]), 15'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        req = '0; head = '0; tail = '0;

        // Round-robin on output 3 among inputs 0..2, single-flit.
        for (int k = 0; k < 6; k++) begin
            logic [4:0] g;
            logic [2:0] s;
            s = 3'(k % 3);
            g = 5'(1 << (k % 3));
            vecs.push_back(mk("rr", 5'b00111, {3'd0,3'd0,3'd3,3'd3,3'd3}, 5'b00111, 5'b00111,
                              5'b11111, g, 5'b01000, {3'd0, s, 3'd0, 3'd0, 3'd0}));
        end
        // Wormhole: input 1 4-flit packet on output 0, input 4 waiting with a head.
        vecs.push_back(mk("wh_head", 5'b10010, 15'd0, 5'b10010, 5'b10000, 5'b11111, 5'b00010, 5'b00001, {12'd0, 3'd1}));
        vecs.push_back(mk("wh_body1",5'b10010, 15'd0, 5'b10000, 5'b10000, 5'b11111, 5'b00010, 5'b00001, {12'd0, 3'd1}));
        vecs.push_back(mk("wh_body2",5'b10010, 15'd0, 5'b10000, 5'b10000, 5'b11111, 5'b00010, 5'b00001, {12'd0, 3'd1}));
        vecs.push_back(mk("wh_tail", 5'b10010, 15'd0, 5'b10000, 5'b10010, 5'b11111, 5'b00010, 5'b00001, {12'd0, 3'd1}));
        // Pointer now 2: input 4 beats input 0.
        vecs.push_back(mk("wh_next", 5'b10001, 15'd0, 5'b10001, 5'b10001, 5'b11111, 5'b10000, 5'b00001, {12'd0, 3'd4}));
        // Backpressure on output 2: input 3 locked, input 0 must not break in.
        vecs.push_back(mk("bp_head", 5'b01000, {3'd0,3'd2,3'd0,3'd0,3'd2}, 5'b01000, 5'b00000, 5'b11111, 5'b01000, 5'b00100, {3'd0,3'd0,3'd3,3'd0,3'd0}));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk("bp_stall", 5'b01001, {3'd0,3'd2,3'd0,3'd0,3'd2}, 5'b00001, 5'b00001, 5'b11011, 5'b00000, 5'b00000, 15'd0));
        vecs.push_back(mk("bp_resume", 5'b01001, {3'd0,3'd2,3'd0,3'd0,3'd2}, 5'b00001, 5'b00001, 5'b11111, 5'b01000, 5'b00100, {3'd0,3'd0,3'd3,3'd0,3'd0}));
        vecs.push_back(mk("bp_tail",   5'b01001, {3'd0,3'd2,3'd0,3'd0,3'd2}, 5'b00001, 5'b01001, 5'b11111, 5'b01000, 5'b00100, {3'd0,3'd0,3'd3,3'd0,3'd0}));
        vecs.push_back(mk("bp_after",  5'b00001, {3'd0,3'd2,3'd0,3'd0,3'd2}, 5'b00001, 5'b00001, 5'b11111, 5'b00001, 5'b00100, 15'd0));
        // All five outputs granted in parallel.
        vecs.push_back(mk("parallel", 5'b11111, {3'd0,3'd1,3'd2,3'd3,3'd4}, 5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111, {3'd0,3'd1,3'd2,3'd3,3'd4}));
        // Out-of-range destinations and a non-head flit at an idle output.
        vecs.push_back(mk("bad_port5", 5'b00010, {3'd0,3'd0,3'd0,3'd5,3'd0}, 5'b00010, 5'b00010, 5'b11111, 5'b00000, 5'b00000, 15'd0));
        vecs.push_back(mk("bad_port7", 5'b00010, {3'd0,3'd0,3'd0,3'd7,3'd0}, 5'b00010, 5'b00010, 5'b11111, 5'b00000, 5'b00000, 15'd0));
        vecs.push_back(mk("nonhead",   5'b00100, {3'd0,3'd0,3'd1,3'd0,3'd0}, 5'b00000, 5'b00100, 5'b11111, 5'b00000, 5'b00000, 15'd0));
        // Pointer wrap on output 0: 3 -> ptr 4, 4 -> ptr 0, then 0 wins.
        vecs.push_back(mk("wrap_in3",  5'b01000, 15'd0, 5'b01000, 5'b01000, 5'b11111, 5'b01000, 5'b00001, {12'd0, 3'd3}));
        vecs.push_back(mk("wrap_in4",  5'b10001, 15'd0, 5'b10001, 5'b10001, 5'b11111, 5'b10000, 5'b00001, {12'd0, 3'd4}));
        vecs.push_back(mk("wrap_in0",  5'b10001, 15'd0, 5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001, {12'd0, 3'd0}));

        foreach (vecs[n]) apply(vecs[n]);

        // Reset mid-packet: lock output 1 to input 3, then pulse reset.
        apply(mk("mr_lock", 5'b01000, {3'd0,3'd1,3'd0,3'd0,3'd0}, 5'b01000, 5'b00000, 5'b11111, 5'b01000, 5'b00010, {3'd0,3'd0,3'd0,3'd3,3'd0}));
        @(negedge clk);
        head = 5'b00000;
        #1 rst = 1'b0;
        #1;
        check("mr_async.grant", 15'(grant), 15'd0);
        check("mr_async.valid", 15'(valid), 15'd0);
        check("mr_async.sel",   15'(sel),   15'd0);
        @(negedge clk);
        rst = 1'b1;
        apply(mk("mr_body",  5'b01000, {3'd0,3'd1,3'd0,3'd0,3'd0}, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 15'd0));
        apply(mk("mr_newhd", 5'b00001, {3'd0,3'd0,3'd0,3'd0,3'd1}, 5'b00001, 5'b00001, 5'b11111, 5'b00001, 5'b00010, 15'd0));

`ifdef SA_GRANT_COUNT_EN
        // Saturation: 70000 single-flit grants on output 0.
        @(negedge clk);
        req = 5'b00001; out_port = '0; head = 5'b00001; tail = 5'b00001; ready = '1;
        repeat (70000) @(negedge clk);
        #1;
        check("cnt_sat", 15'(grant_cnt[0] == 16'hFFFF), 15'd1);
`endif

        if (expq.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-cycle switch allocator that drives the router crossbar's select lines.
- Each input port holds one head-of-line flit. The input port asks for one output port and says whether the flit is a head and/or a tail.
- One round-robin arbiter per output chooses a winner. Each output locks to that input until the packet's tail flit is granted (wormhole).
- Grants, crossbar selects and output valids are combinational in the request cycle. Round-robin pointers and lock state are registered.

Parameters:
- INPUT_NUM, 5, number of crossbar inputs (input ports).
- OUTPUT_NUM, 5, number of crossbar outputs (output ports).
- SEL_SIZE, utils::clogb2(INPUT_NUM), localparam, width of each crossbar select.
- OUT_SIZE, utils::clogb2(OUTPUT_NUM), localparam, width of a destination port index.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_i  in  [INPUT_NUM-1:0]  input i presents a valid flit.
- out_port_i  in  [OUT_SIZE-1:0] x INPUT_NUM  requested output of input i.
- head_i  in  [INPUT_NUM-1:0]  flit on input i is a head flit.
- tail_i  in  [INPUT_NUM-1:0]  flit on input i is a tail flit; head&tail means a single-flit packet.
- out_ready_i  in  [OUTPUT_NUM-1:0]  downstream of output o can accept a flit this cycle (credit available).
- grant_o  out  [INPUT_NUM-1:0]  input i's flit traverses this cycle; the input dequeues at the clock edge.
- sel_o  out  [SEL_SIZE-1:0] x OUTPUT_NUM  crossbar select per output.
- valid_o  out  [OUTPUT_NUM-1:0]  output o carries a flit this cycle.

Behaviour:
- State per output o: state_q in {IDLE, LOCKED}, owner_q[SEL_SIZE], ptr_q[SEL_SIZE]. Reset values: IDLE, 0, 0.
- Eligibility of input i for output o:
  - requires req_i[i], out_port_i[i]==o and out_ready_i[o];
  - IDLE: head_i[i]=1 is also required;
  - LOCKED: i==owner_q is also required; head_i is ignored.
- out_port_i >= OUTPUT_NUM: the request is ignored and no grant is given.
- IDLE winner: first eligible input scanning ptr_q, ptr_q+1, ... with wrap modulo INPUT_NUM. LOCKED winner: owner_q if eligible, else none.
- Outputs with a winner w:
  - valid_o[o]=1, sel_o[o]=w, grant_o[w]=1;
  - no winner: valid_o[o]=0, sel_o[o]=0.
  - Each input asks for exactly one output, so grant_o is one-hot or zero per input.
- Next state on a grant to w at output o:
  - IDLE and tail_i[w]=0: go LOCKED, owner_q<=w.
  - IDLE and tail_i[w]=1: stay IDLE, ptr_q<=(w+1) mod INPUT_NUM.
  - LOCKED and tail_i[w]=1: go IDLE, ptr_q<=(owner_q+1) mod INPUT_NUM.
  - LOCKED and tail_i[w]=0: stay LOCKED.
- No grant at output o: state, owner and pointer all hold. A LOCKED output stalls while the owner is absent or out_ready_i is low; other inputs never break in.
- Non-head flit at an IDLE output: not eligible and stays ungranted (protocol violation).
- Latency: zero cycles, request to grant. Pointer and lock updates are visible the next cycle.
- Reset asserted mid-packet: all locks release to IDLE and pointers return to 0 immediately. All outputs read 0 while rst is low.
- Pointer wrap: ptr_q = INPUT_NUM-1 followed by a tail grant wraps to 0. The index never reaches INPUT_NUM.

Optional Feature:
- Macro: SA_GRANT_COUNT_EN.
- Defined:
  - adds output grant_cnt_o [15:0] x OUTPUT_NUM;
  - the counter increments each cycle valid_o[o]=1 and saturates at 16'hFFFF (no wrap);
  - reset value 0.
- Undefined: the port and the counters are absent; allocation behaviour is identical.

Test Plan:
- Basic round-robin, after reset:
  - inputs 0,1,2 request output 3 with head=tail=1 every cycle, out_ready=all 1;
  - grants rotate 0,1,2,0,1,2;
  - sel_o[3] follows 0,1,2,...; valid_o[3]=1 every cycle.
- Wormhole lock:
  - input 1 sends a 4-flit packet to output 0 (head, body, body, tail) while input 4 keeps a head request to output 0;
  - input 1 gets 4 consecutive grants; input 4 is first granted in the cycle after the tail;
  - ptr_q[0]=2 after the tail.
- Backpressure: out_ready_i[2]=0 for 3 cycles mid-packet, then 1. Required response:
  - valid_o[2]=0 and no grant during the stall;
  - the lock holds; the same owner resumes when ready returns.
- Parallel outputs: inputs 0..4 request outputs 4,3,2,1,0 respectively, single-flit. Required response: grant_o=5'b11111, sel_o = {0,1,2,3,4} for outputs 4..0, all valid in the same cycle.
- Reset mid-packet: assert rst low while output 1 is LOCKED to input 3. Required response:
  - outputs read 0 asynchronously;
  - after release, a body flit from input 3 is not granted;
  - a new head from input 0 is granted.
- Pointer wrap and counter:
  - single-flit grant to input 4 at output 0 gives ptr 0, so inputs 0 and 4 then competing pick 0;
  - with SA_GRANT_COUNT_EN defined, 70000 grants read grant_cnt_o = 16'hFFFF.
